mem_req_initiator: RTL and testbench

//  Load/store initiator on the MEM stage. Accepts one access per handshake from the pipeline and

---
 rtl/mem_req_initiator_pkg.sv | 20 ++
 rtl/mem_req_initiator_if.sv | 22 ++
 rtl/mem_lane_align.sv | 54 +++++
 rtl/mem_req_initiator.sv | 142 ++++++++++++++
 tb/tb_mem_req_initiator.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_req_initiator_pkg.sv
// Shared definitions for the MEM-stage load/store initiator: size codes, FSM states and default limits.
package mem_defs;

  localparam logic [31:0] DEF_ADDR_LIMIT = 32'h0000_3000;
  localparam int          DEF_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_req_initiator_if.sv
// Data-memory req/ack bus between the initiator (master) and the memory (slave).
interface mem_req_initiator_if;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: byte enables, store-data replication and load extraction/extension.
module mem_lane_align
  import mem_defs::*;
(
  input  logic [1:0]  addr_lo,
  input  size_t       size,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_placed,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel     = 8'h00;
    half_sel     = 16'h0000;
    be           = 4'h0;
    wdata_placed = 32'h0;
    rdata_ext    = 32'h0;

    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Illegal size leaves everything zero; such accesses never reach the bus anyway.
    case (size)
      SZ_BYTE: begin
        be           = 4'b0001 << addr_lo;
        wdata_placed = {4{wdata[7:0]}};
        rdata_ext    = {{24{sign & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be           = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_placed = {2{wdata[15:0]}};
        rdata_ext    = {{16{sign & half_sel[15]}}, half_sel};
      end
      SZ_WORD: begin
        be           = 4'hF;
        wdata_placed = wdata;
        rdata_ext    = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_req_initiator.sv
// MEM-stage load/store initiator: one outstanding access, alignment/range/timeout error checking.
// Define DM_TRACE_EN to print a trace line on every acknowledged store.
module mem_req_initiator
  import mem_defs::*;
#(
  parameter logic [31:0] ADDR_LIMIT = DEF_ADDR_LIMIT,
  parameter int          TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_sign,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [31:0]         req_pc,
  output logic                rsp_valid,
  output logic [31:0]         rsp_rdata,
  output logic                rsp_err,
  mem_req_initiator_if.master mem
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_next;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  size_t         size_q;
  logic          we_q, sign_q, err_q;
  logic [CW-1:0] wait_cnt;
  logic          accept, illegal, timed_out, in_req;
  logic [3:0]    be;
  logic [31:0]   wdata_placed, rdata_ext;

  assign accept    = req_valid && (state == ST_IDLE);
  assign illegal   = (size_t'(req_size) == SZ_ILL) ||
                     ((size_t'(req_size) == SZ_HALF) && req_addr[0]) ||
                     ((size_t'(req_size) == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
                     (req_addr >= ADDR_LIMIT);
  assign timed_out = (wait_cnt == CNT_LAST) && !mem.mem_ack;
  assign in_req    = (state == ST_REQ);

  // State register; async reset drops mem_req at once because it decodes straight from state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next   = state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    mem.mem_req  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = illegal ? ST_RESP : ST_REQ;
      end
      ST_REQ: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ack || timed_out) state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Request capture, wait counter and response data/error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      size_q   <= SZ_BYTE;
      we_q     <= 1'b0;
      sign_q   <= 1'b0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else if (accept) begin
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      rdata_q  <= 32'h0;
      size_q   <= size_t'(req_size);
      we_q     <= req_we;
      sign_q   <= req_sign;
      err_q    <= illegal;
      wait_cnt <= '0;
    end else if (in_req) begin
      if (mem.mem_ack) begin
        rdata_q <= we_q ? 32'h0 : rdata_ext;
        err_q   <= 1'b0;
      end else begin
        if (timed_out) err_q <= 1'b1;
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  mem_lane_align u_align (
    .addr_lo      (addr_q[1:0]),
    .size         (size_q),
    .sign         (sign_q),
    .wdata        (wdata_q),
    .rdata        (mem.mem_rdata),
    .be           (be),
    .wdata_placed (wdata_placed),
    .rdata_ext    (rdata_ext)
  );

  assign mem.mem_we    = in_req && we_q;
  assign mem.mem_be    = in_req ? be : 4'h0;
  assign mem.mem_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem.mem_wdata = in_req ? wdata_placed : 32'h0;
  assign rsp_rdata     = rsp_valid ? rdata_q : 32'h0;
  assign rsp_err       = rsp_valid && err_q;

`ifdef DM_TRACE_EN
  logic [31:0] pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      pc_q <= 32'h0;
    else if (accept) pc_q <= req_pc;
  end

  // Disabled byte lanes print as zero.
  always @(posedge clk) begin
    if (reset && in_req && mem.mem_ack && we_q)
      $display("@%h: *%h <= %h", pc_q, mem.mem_addr,
               mem.mem_wdata & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}});
  end
`else
  logic pc_unused;
  assign pc_unused = ^req_pc;
`endif

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed, table-driven bench for mem_req_initiator plus hand-written multi-cycle sequences.
module tb_mem_req_initiator;
  import mem_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int compared   = 0;
  int mismatched = 0;

  mem_req_initiator_if mif ();

  mem_req_initiator dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_sign  (req_sign),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_pc    (req_pc),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem       (mif.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mword;
    logic        legal;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs one access from IDLE through RESP with a zero-wait memory.
  task automatic applyStimulus(input vec_t v, input string tag);
    checkOutput({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = v.we;
    req_size  = v.size;
    req_sign  = v.sign;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_pc    = 32'h0000_1000 + v.addr;
    step();
    req_valid = 1'b0;
    if (v.legal) begin
      checkOutput({tag, "_mem_req"},   32'(mif.mem_req), 32'd1);
      checkOutput({tag, "_mem_we"},    32'(mif.mem_we), 32'(v.we));
      checkOutput({tag, "_mem_addr"},  mif.mem_addr, {v.addr[31:2], 2'b00});
      checkOutput({tag, "_mem_be"},    32'(mif.mem_be), 32'(v.exp_be));
      checkOutput({tag, "_mem_wdata"}, mif.mem_wdata, v.exp_wdata);
      checkOutput({tag, "_ready_req"}, 32'(req_ready), 32'd0);
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = v.mword;
      step();
      mif.mem_ack   = 1'b0;
      mif.mem_rdata = 32'h0;
    end else begin
      checkOutput({tag, "_no_mem_req"}, 32'(mif.mem_req), 32'd0);
    end
    checkOutput({tag, "_rsp_valid"},  32'(rsp_valid), 32'd1);
    checkOutput({tag, "_rsp_err"},    32'(rsp_err), 32'(!v.legal));
    checkOutput({tag, "_rsp_rdata"},  rsp_rdata, v.legal ? v.exp_rdata : 32'h0);
    checkOutput({tag, "_ready_resp"}, 32'(req_ready), 32'd0);
    step();
    checkOutput({tag, "_rsp_drop"},   32'(rsp_valid), 32'd0);
    checkOutput({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          cnt;
    logic        seen;
    vec_t        v;

    //            we    size  sign  addr           wdata          mword          legal be       exp_wdata      exp_rdata
    vecs[0]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,         32'h80FF_1234, 1'b1, 4'b1000, 32'h0,         32'hFFFF_FF80};
    vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0,         32'h80FF_1234, 1'b1, 4'b0010, 32'h0,         32'h0000_0012};
    vecs[2]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0042, 32'h0,         32'h80FF_1234, 1'b1, 4'b1100, 32'h0,         32'hFFFF_80FF};
    vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0040, 32'h0,         32'h80FF_1234, 1'b1, 4'b0011, 32'h0,         32'h0000_1234};
    vecs[4]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0040, 32'h0,         32'h0000_9ABC, 1'b1, 4'b0011, 32'h0,         32'hFFFF_9ABC};
    vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h0000_2FFC, 32'h0,         32'hDEAD_BEEF, 1'b1, 4'b1111, 32'h0,         32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h1234_ABCD, 32'h5555_5555, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[7]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0001, 32'h0000_00A5, 32'h5555_5555, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h0123_4567, 32'h5555_5555, 1'b1, 4'b1111, 32'h0123_4567, 32'h0};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0,         32'h0,         1'b0, 4'b0000, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 2'd2, 1'b0, 32'h0000_3000, 32'h1111_2222, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0};
    vecs[11] = '{1'b0, 2'd1, 1'b1, 32'h0000_0041, 32'h0,         32'h0,         1'b0, 4'b0000, 32'h0,         32'h0};
    vecs[12] = '{1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         1'b0, 4'b0000, 32'h0,         32'h0};
    vecs[13] = '{1'b0, 2'd0, 1'b1, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b0, 4'b0000, 32'h0,         32'h0};
    vecs[14] = '{1'b0, 2'd0, 1'b1, 32'h0000_0100, 32'h0,         32'h80FF_1234, 1'b1, 4'b0001, 32'h0,         32'h0000_0034};
    vecs[15] = '{1'b0, 2'd0, 1'b0, 32'h0000_0102, 32'h0,         32'h80FF_1234, 1'b1, 4'b0100, 32'h0,         32'h0000_00FF};

    reset         = 1'b0;
    req_valid     = 1'b0;
    req_we        = 1'b0;
    req_size      = 2'd0;
    req_sign      = 1'b0;
    req_addr      = 32'h0;
    req_wdata     = 32'h0;
    req_pc        = 32'h0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 32'h0;
    step();
    step();
    checkOutput("rst_ready",     32'(req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_err",   32'(rsp_err), 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_mem_req",   32'(mif.mem_req), 32'd0);
    checkOutput("rst_mem_be",    32'(mif.mem_be), 32'd0);
    checkOutput("rst_mem_addr",  mif.mem_addr, 32'h0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i], $sformatf("v%0d", i));

    // Stray ack while idle must not produce a response.
    mif.mem_ack = 1'b1;
    step();
    mif.mem_ack = 1'b0;
    checkOutput("idle_ack_rsp",  32'(rsp_valid), 32'd0);
    checkOutput("idle_ack_req",  32'(mif.mem_req), 32'd0);

    // lhu at 0x2 with a memory that never acknowledges.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd1; req_sign = 1'b0; req_addr = 32'h2;
    step();
    req_valid = 1'b0;
    cnt  = 0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      if (mif.mem_req) cnt++;
      step();
    end
    checkOutput("to_rsp_seen",   32'(seen), 32'd1);
    checkOutput("to_req_cycles", 32'(cnt), 32'd16);
    checkOutput("to_rsp_err",    32'(rsp_err), 32'd1);
    checkOutput("to_rsp_rdata",  rsp_rdata, 32'h0);
    checkOutput("to_mem_req",    32'(mif.mem_req), 32'd0);
    step();
    checkOutput("to_ready_back", 32'(req_ready), 32'd1);

    // Reset asserted while the access waits for ack.
    req_valid = 1'b1; req_size = 2'd0; req_addr = 32'h0;
    step();
    req_valid = 1'b0;
    checkOutput("rr_mem_req_before", 32'(mif.mem_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rr_mem_req_async", 32'(mif.mem_req), 32'd0);
    step();
    checkOutput("rr_no_rsp0", 32'(rsp_valid), 32'd0);
    step();
    checkOutput("rr_no_rsp1", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    step();
    checkOutput("rr_no_rsp2", 32'(rsp_valid), 32'd0);
    applyStimulus(vecs[15], "rr_lbu");

    // Back-to-back with req_valid held high across two accesses.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_sign = 1'b0; req_addr = 32'h0;
    step();
    checkOutput("bb_ready_req1", 32'(req_ready), 32'd0);
    checkOutput("bb_mem_req1",   32'(mif.mem_req), 32'd1);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0000_00C3;
    step();
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
    checkOutput("bb_rsp1",        32'(rsp_valid), 32'd1);
    checkOutput("bb_rdata1",      rsp_rdata, 32'h0000_00C3);
    checkOutput("bb_ready_resp1", 32'(req_ready), 32'd0);
    req_addr = 32'h1;
    step();
    checkOutput("bb_ready_idle", 32'(req_ready), 32'd1);
    checkOutput("bb_mem_idle",   32'(mif.mem_req), 32'd0);
    step();
    req_valid = 1'b0;
    checkOutput("bb_mem_req2",   32'(mif.mem_req), 32'd1);
    checkOutput("bb_be2",        32'(mif.mem_be), 32'h2);
    checkOutput("bb_ready_req2", 32'(req_ready), 32'd0);
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0000_C300;
    step();
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
    checkOutput("bb_rsp2",   32'(rsp_valid), 32'd1);
    checkOutput("bb_rdata2", rsp_rdata, 32'h0000_00C3);
    step();
    checkOutput("bb_ready_end", 32'(req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
